// File: rtl/card_rom_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : card_rom_arbiter
// Purpose  : Round-robin sharing of one synchronous card-bitmap ROM read port
//            between N_REQ render requesters, with tagged, fixed-latency
//            responses. Define ROM_ARB_STATS_EN to add the conflict_cnt output.
// Revision : 1.0 - initial release
// ============================================================================
module card_rom_arbiter #(
    parameter int N_REQ   = 4,
    parameter int ADDR_W  = 12,
    parameter int DATA_W  = 12,
    parameter int ROM_LAT = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      frame_sync,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*ADDR_W-1:0]   req_addr,
    output logic [N_REQ-1:0]          gnt,
    output logic                      rom_en,
    output logic [ADDR_W-1:0]         rom_addr,
    input  logic [DATA_W-1:0]         rom_data,
    output logic                      rsp_valid,
    output logic [$clog2(N_REQ)-1:0]  rsp_id,
    output logic [DATA_W-1:0]         rsp_data
`ifdef ROM_ARB_STATS_EN
    ,
    output logic [15:0]               conflict_cnt
`endif
);

    localparam int ID_W = $clog2(N_REQ);
    localparam logic [ID_W:0]   C_NREQ = (ID_W+1)'(N_REQ);
    localparam logic [ID_W-1:0] C_LAST = ID_W'(N_REQ - 1);

    logic [ID_W-1:0]   r_ptr;
    logic [ADDR_W-1:0] r_rom_addr;
    logic [ROM_LAT:0]  r_tag_v;
    logic [ID_W-1:0]   r_tag_id [0:ROM_LAT];
    logic              r_rsp_valid;
    logic [ID_W-1:0]   r_rsp_id;
    logic [DATA_W-1:0] r_rsp_data;

    logic [N_REQ-1:0]  w_gnt;
    logic [ID_W-1:0]   w_win;
    logic              w_any;
    logic [ID_W:0]     w_cand;
    logic [ID_W-1:0]   w_ptr_nxt;

    // Rotating priority search; the grant is forced low while reset is held.
    always_comb begin
        w_gnt  = '0;
        w_win  = '0;
        w_any  = 1'b0;
        w_cand = '0;
        if (!rst) begin
            for (int j = 0; j < N_REQ; j++) begin
                w_cand = {1'b0, r_ptr} + (ID_W+1)'(j);
                if (w_cand >= C_NREQ) begin
                    w_cand = w_cand - C_NREQ;
                end
                if (!w_any && req[w_cand[ID_W-1:0]]) begin
                    w_any = 1'b1;
                    w_win = w_cand[ID_W-1:0];
                end
            end
        end
        if (w_any) begin
            w_gnt[w_win] = 1'b1;
        end
    end

    always_comb begin
        w_ptr_nxt = r_ptr;
        if (frame_sync) begin
            w_ptr_nxt = '0;
        end else if (w_any) begin
            w_ptr_nxt = (w_win == C_LAST) ? '0 : w_win + 1'b1;
        end
    end

    // Tag stage 0 coincides with rom_en; stage ROM_LAT lines up with rom_data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr       <= '0;
            r_rom_addr  <= '0;
            r_tag_v     <= '0;
            for (int i = 0; i <= ROM_LAT; i++) begin
                r_tag_id[i] <= '0;
            end
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_data  <= '0;
        end else begin
            r_ptr <= w_ptr_nxt;
            if (w_any) begin
                r_rom_addr <= req_addr[w_win*ADDR_W +: ADDR_W];
            end
            r_tag_v     <= {r_tag_v[ROM_LAT-1:0], w_any};
            r_tag_id[0] <= w_win;
            for (int i = 1; i <= ROM_LAT; i++) begin
                r_tag_id[i] <= r_tag_id[i-1];
            end
            r_rsp_valid <= r_tag_v[ROM_LAT];
            r_rsp_id    <= r_tag_id[ROM_LAT];
            r_rsp_data  <= rom_data;
        end
    end

    assign gnt       = w_gnt;
    assign rom_en    = r_tag_v[0];
    assign rom_addr  = r_rom_addr;
    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp_id;
    assign rsp_data  = r_rsp_data;

`ifdef ROM_ARB_STATS_EN
    logic [15:0] r_conflict_cnt;
    logic        w_multi;

    // Clearing x & (x-1) drops the lowest set bit; anything left means 2+ requests.
    assign w_multi = |(req & (req - N_REQ'(1)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_conflict_cnt <= '0;
        end else if (frame_sync) begin
            r_conflict_cnt <= '0;
        end else if (w_multi && (r_conflict_cnt != 16'hFFFF)) begin
            r_conflict_cnt <= r_conflict_cnt + 16'd1;
        end
    end

    assign conflict_cnt = r_conflict_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_card_rom_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_card_rom_arbiter
// Purpose  : Directed and random stimulus for card_rom_arbiter with a
//            response scoreboard fed by the stimulus and drained by a monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_card_rom_arbiter;

    localparam int N       = 4;
    localparam int AW      = 12;
    localparam int DW      = 12;
    localparam int LAT     = 2;

    typedef struct {
        int          id;
        logic [11:0] data;
        int          due;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              frame_sync = 1'b0;
    logic [N-1:0]      req = '0;
    logic [N*AW-1:0]   req_addr = '0;
    logic [N-1:0]      gnt;
    logic              rom_en;
    logic [AW-1:0]     rom_addr;
    logic [DW-1:0]     rom_data;
    logic              rsp_valid;
    logic [1:0]        rsp_id;
    logic [DW-1:0]     rsp_data;
`ifdef ROM_ARB_STATS_EN
    logic [15:0]       conflict_cnt;
`endif

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   m_ptr    = 0;
    exp_t sb[$];
    logic [DW-1:0] rom_pipe [0:LAT-1];

    card_rom_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .ROM_LAT(LAT)) dut (
        .clk        (clk),
        .rst        (rst),
        .frame_sync (frame_sync),
        .req        (req),
        .req_addr   (req_addr),
        .gnt        (gnt),
        .rom_en     (rom_en),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .rsp_valid  (rsp_valid),
        .rsp_id     (rsp_id),
        .rsp_data   (rsp_data)
`ifdef ROM_ARB_STATS_EN
        ,
        .conflict_cnt (conflict_cnt)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // ROM model: data = address ^ 12'hFFF, LAT cycles after the address.
    always @(posedge clk) begin
        rom_pipe[0] <= rom_addr ^ 12'hFFF;
        for (int i = 1; i < LAT; i++) rom_pipe[i] <= rom_pipe[i-1];
    end
    assign rom_data = rom_pipe[LAT-1];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [N-1:0] model_arb(input logic [N-1:0] r, input int p);
        for (int j = 0; j < N; j++) begin
            if (r[(p + j) % N]) return N'(1) << ((p + j) % N);
        end
        return '0;
    endfunction

    // One arbitration cycle: apply inputs, check gnt, queue the expected response.
    task automatic drive(input logic [N-1:0] r, input logic [N*AW-1:0] a,
                         input logic fs, input logic [N-1:0] eg);
        exp_t e;
        @(posedge clk);
        #1;
        req = r; req_addr = a; frame_sync = fs;
        #1;
        chk("gnt", 32'(gnt), 32'(eg));
        if (eg != '0) begin
            for (int k = 0; k < N; k++) begin
                if (eg[k]) begin
                    e.id   = k;
                    e.data = a[k*AW +: AW] ^ 12'hFFF;
                    e.due  = cyc + LAT + 2;
                    sb.push_back(e);
                    m_ptr = (k + 1) % N;
                end
            end
        end
        if (fs) m_ptr = 0;
    endtask

    // Monitor: every due response must appear exactly on time; nothing else may.
    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            n_checks++;
            if (!rsp_valid || rsp_id !== 2'(e.id) || rsp_data !== e.data || e.due != cyc) begin
                n_fail++;
                $display("FAIL rsp: got valid=%b id=%0d data=%h at cycle %0d expected id=%0d data=%h at cycle %0d",
                         rsp_valid, rsp_id, rsp_data, cyc, e.id, e.data, e.due);
            end
        end else if (rsp_valid) begin
            n_checks++;
            n_fail++;
            $display("FAIL rsp_unexpected: got id=%0d data=%h expected no response (cycle %0d)",
                     rsp_id, rsp_data, cyc);
        end
    end

    localparam logic [N*AW-1:0] A_T1 = {12'h000, 12'h0A5, 12'h000, 12'h000};
    localparam logic [N*AW-1:0] A_Q  = {12'h433, 12'h322, 12'h211, 12'h100};

    initial begin
        logic [N-1:0]    rr;
        logic [N*AW-1:0] ra;
        logic            rf;

        // Reset state, with all requests raised to show gnt stays low.
        req = 4'b1111;
        #2;
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_rom_en", 32'(rom_en), 0);
        chk("rst_rom_addr", 32'(rom_addr), 0);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_rsp_id", 32'(rsp_id), 0);
        chk("rst_rsp_data", 32'(rsp_data), 0);
        req = '0;
        #21 rst = 1'b0;
        m_ptr = 0;

        // 1: single request from requester 2.
        drive(4'b0100, A_T1, 1'b0, 4'b0100);
        drive(4'b0000, '0, 1'b0, 4'b0000);
        chk("t1_rom_en", 32'(rom_en), 1);
        chk("t1_rom_addr", 32'(rom_addr), 32'h0A5);
        drive(4'b0000, '0, 1'b0, 4'b0000);
        chk("t1_rom_en_idle", 32'(rom_en), 0);
        chk("t1_rom_addr_hold", 32'(rom_addr), 32'h0A5);
        repeat (4) drive(4'b0000, '0, 1'b0, 4'b0000);

        // 2: all requesting after a frame_sync re-seed.
        drive(4'b0000, '0, 1'b1, 4'b0000);
        for (int i = 0; i < 8; i++) drive(4'b1111, A_Q, 1'b0, 4'b0001 << (i % 4));
        repeat (6) drive(4'b0000, '0, 1'b0, 4'b0000);

        // 3: frame_sync re-seed, then simultaneous frame_sync with a grant.
        drive(4'b1010, A_Q, 1'b0, 4'b0010);
        drive(4'b0000, A_Q, 1'b1, 4'b0000);
        drive(4'b1010, A_Q, 1'b0, 4'b0010);
        drive(4'b1010, A_Q, 1'b0, 4'b1000);
        drive(4'b1010, A_Q, 1'b1, 4'b0010);
        drive(4'b1010, A_Q, 1'b0, 4'b0010);
        repeat (6) drive(4'b0000, '0, 1'b0, 4'b0000);

        // 4: reset two cycles after a grant drops every in-flight tag.
        drive(4'b0001, A_Q, 1'b0, 4'b0001);
        drive(4'b0010, A_Q, 1'b0, 4'b0010);
        drive(4'b1111, A_Q, 1'b0, 4'b0100);
        #1 rst = 1'b1;
        sb.delete();
        m_ptr = 0;
        #1;
        chk("arst_gnt", 32'(gnt), 0);
        chk("arst_rom_en", 32'(rom_en), 0);
        chk("arst_rom_addr", 32'(rom_addr), 0);
        chk("arst_rsp_valid", 32'(rsp_valid), 0);
        chk("arst_rsp_data", 32'(rsp_data), 0);
        @(posedge clk);
        #3;
        req = '0;
        rst = 1'b0;
        repeat (8) drive(4'b0000, '0, 1'b0, 4'b0000);

        // 5: random traffic checked against the reference arbiter.
        for (int i = 0; i < 1500; i++) begin
            rr = N'($urandom_range(0, 15));
            ra = {12'($urandom), 12'($urandom), 12'($urandom), 12'($urandom)};
            rf = ($urandom_range(0, 15) == 0);
            drive(rr, ra, rf, model_arb(rr, m_ptr));
        end
        repeat (6) drive(4'b0000, '0, 1'b0, 4'b0000);

`ifdef ROM_ARB_STATS_EN
        // 6: conflict counter counts, then clears on frame_sync.
        drive(4'b0000, '0, 1'b1, 4'b0000);
        for (int i = 0; i < 5; i++) drive(4'b0011, A_Q, 1'b0, (i % 2 == 0) ? 4'b0001 : 4'b0010);
        drive(4'b0000, '0, 1'b1, 4'b0000);
        chk("conflict_cnt_5", 32'(conflict_cnt), 5);
        drive(4'b0000, '0, 1'b0, 4'b0000);
        chk("conflict_cnt_clr", 32'(conflict_cnt), 0);
        repeat (6) drive(4'b0000, '0, 1'b0, 4'b0000);
`endif

        chk("sb_drained", 32'(sb.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
